// File: rtl/cordic_rr_sched_if.sv
// Request, CORDIC-core and result handshake bundle for cordic_rr_sched.
// The scheduler sits on the slave modport; the environment drives the master side.
interface cordic_rr_sched_if #(
    parameter int WIDTH = 12
);
    logic             req0_valid;
    logic             req1_valid;
    logic [WIDTH-1:0] req0_angle;
    logic [WIDTH-1:0] req1_angle;
    logic             req0_ready;
    logic             req1_ready;

    logic             core_start;
    logic [WIDTH-1:0] core_x0;
    logic [WIDTH-1:0] core_y0;
    logic [WIDTH-1:0] core_z0;
    logic             core_done;
    logic [WIDTH-1:0] core_cos;
    logic [WIDTH-1:0] core_sin;

    logic             out_valid;
    logic             out_ready;
    logic             out_chan;
    logic [WIDTH-1:0] out_cos;
    logic [WIDTH-1:0] out_sin;
    logic             out_err;

    modport slave (
        input  req0_valid, req1_valid, req0_angle, req1_angle,
        output req0_ready, req1_ready,
        output core_start, core_x0, core_y0, core_z0,
        input  core_done, core_cos, core_sin,
        output out_valid, out_chan, out_cos, out_sin, out_err,
        input  out_ready
    );

    modport master (
        output req0_valid, req1_valid, req0_angle, req1_angle,
        input  req0_ready, req1_ready,
        input  core_start, core_x0, core_y0, core_z0,
        output core_done, core_cos, core_sin,
        input  out_valid, out_chan, out_cos, out_sin, out_err,
        output out_ready
    );
endinterface

// File: rtl/cordic_rr_sched.sv
// Two-channel round-robin front end for an iterative CORDIC core, with done timeout.
// Define CORDIC_QUAD_FOLD_EN to fold angles in the left half-plane and negate results.
module cordic_rr_sched #(
    parameter int WIDTH   = 12,
    parameter int X0      = 1243,
    parameter int TIMEOUT = 64
) (
    input  logic             clock,
    input  logic             resetn,
    cordic_rr_sched_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

    state_t           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic             chan_q, chan_d;
    logic [WIDTH-1:0] angle_q, angle_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             out_chan_q, out_chan_d;
    logic [WIDTH-1:0] out_cos_q, out_cos_d;
    logic [WIDTH-1:0] out_sin_q, out_sin_d;
    logic             out_err_q, out_err_d;

    logic             grant;
    logic             accept;
    logic             timed_out;
    logic [WIDTH-1:0] z0;
    logic [WIDTH-1:0] res_cos;
    logic [WIDTH-1:0] res_sin;

`ifdef CORDIC_QUAD_FOLD_EN
    localparam logic [WIDTH-1:0] HALF   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAXPOS = {1'b0, {(WIDTH-1){1'b1}}};

    logic fold;

    function automatic logic [WIDTH-1:0] negSat(input logic [WIDTH-1:0] v);
        return (v == HALF) ? MAXPOS : -v;
    endfunction

    // Angles whose top two bits differ lie in [pi/2, 3pi/2); rotate by pi.
    assign fold    = angle_q[WIDTH-1] ^ angle_q[WIDTH-2];
    assign z0      = fold ? (angle_q ^ HALF) : angle_q;
    assign res_cos = fold ? negSat(bus.core_cos) : bus.core_cos;
    assign res_sin = fold ? negSat(bus.core_sin) : bus.core_sin;
`else
    assign z0      = angle_q;
    assign res_cos = bus.core_cos;
    assign res_sin = bus.core_sin;
`endif

    // ptr_q holds the last served channel; it only breaks ties.
    always_comb begin
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ~ptr_q;
        end else begin
            grant = bus.req1_valid;
        end
    end

    assign accept    = (state_q == IDLE) && resetn && (bus.req0_valid || bus.req1_valid);
    assign timed_out = (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (bus.core_done || timed_out) state_d = OUT;
            OUT:     if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req0_ready = accept && !grant;
        bus.req1_ready = accept && grant;
        bus.core_start = (state_q == ISSUE);
        bus.out_valid  = (state_q == OUT);
        bus.core_x0    = '0;
        bus.core_y0    = '0;
        bus.core_z0    = '0;
        if (state_q == ISSUE || state_q == WAIT) begin
            bus.core_x0 = WIDTH'(X0);
            bus.core_z0 = z0;
        end
    end

    // A done arriving on the final counted cycle wins over the timeout.
    always_comb begin
        ptr_d      = ptr_q;
        chan_d     = chan_q;
        angle_d    = angle_q;
        cnt_d      = '0;
        out_chan_d = out_chan_q;
        out_cos_d  = out_cos_q;
        out_sin_d  = out_sin_q;
        out_err_d  = out_err_q;
        if (accept) begin
            ptr_d   = grant;
            chan_d  = grant;
            angle_d = grant ? bus.req1_angle : bus.req0_angle;
        end
        if (state_q == WAIT) begin
            cnt_d = cnt_q + CW'(1);
            if (bus.core_done) begin
                out_chan_d = chan_q;
                out_cos_d  = res_cos;
                out_sin_d  = res_sin;
                out_err_d  = 1'b0;
            end else if (timed_out) begin
                out_chan_d = chan_q;
                out_cos_d  = '0;
                out_sin_d  = '0;
                out_err_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ptr_q      <= 1'b1;
            chan_q     <= 1'b0;
            angle_q    <= '0;
            cnt_q      <= '0;
            out_chan_q <= 1'b0;
            out_cos_q  <= '0;
            out_sin_q  <= '0;
            out_err_q  <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            chan_q     <= chan_d;
            angle_q    <= angle_d;
            cnt_q      <= cnt_d;
            out_chan_q <= out_chan_d;
            out_cos_q  <= out_cos_d;
            out_sin_q  <= out_sin_d;
            out_err_q  <= out_err_d;
        end
    end

    assign bus.out_chan = out_chan_q;
    assign bus.out_cos  = out_cos_q;
    assign bus.out_sin  = out_sin_q;
    assign bus.out_err  = out_err_q;
endmodule
